// File: rtl/jk_cnt_pkg.sv
// jk_cnt_pkg: shared JK excitation encodings, default width and mask helper
package jk_cnt_pkg;
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RESET = 2'b01;
  localparam logic [1:0] JK_SET = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;
  localparam int DEFAULT_WIDTH = 4;
  function automatic logic [15:0] all_ones(input int width);
    return 16'((32'd1 << width) - 32'd1);
  endfunction
endpackage

// File: rtl/jk_ff_cell.sv
// jk_ff_cell: single-bit JK flip-flop (no reset; reset arrives as J/K excitation)
// Ports: Clk clock, J/K excitation in, Q/Q_not state out.
module jk_ff_cell (
  input  logic Clk,
  input  logic J,
  input  logic K,
  output logic Q,
  output logic Q_not
);
  always_ff @(posedge Clk) Q <= (J & ~Q) | (~K & Q);
  assign Q_not = ~Q;
endmodule

// File: rtl/jk_sync_counter.sv
// jk_sync_counter: WIDTH-bit synchronous up/down counter built from JK cells
// Ports: Clk clock; RST sync active-high reset; En enable; Up direction;
// Load/D parallel load; Q count; TC terminal count; J_mon/K_mon excitation.
// Macro JK_CNT_SATURATE_EN: hold at the terminal value instead of wrapping.
module jk_sync_counter
  import jk_cnt_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             Clk,
  input  logic             RST,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic [WIDTH-1:0] J_mon,
  output logic [WIDTH-1:0] K_mon
);
  localparam logic [15:0] ONES = all_ones(WIDTH);
  logic [WIDTH-1:0] q, q_n, tog;
  logic [WIDTH-1:0][1:0] jk;
  logic ones_pre, zeros_pre, sat;
  assign Q = q;
  assign TC = En & ~Load & ~RST & ((Up & (q == ONES[WIDTH-1:0])) | (~Up & (q == '0)));
`ifdef JK_CNT_SATURATE_EN
  assign sat = TC;
`else
  assign sat = 1'b0;
`endif
  // Bit i toggles when every lower bit is 1 (up) or 0 (down); running prefixes.
  always_comb begin
    ones_pre = 1'b1;
    zeros_pre = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      tog[i] = Up ? ones_pre : zeros_pre;
      ones_pre = ones_pre & q[i];
      zeros_pre = zeros_pre & q_n[i];
    end
  end
  // Reset and load are applied as set/clear excitation through the cells.
  always_comb begin
    for (int i = 0; i < WIDTH; i++)
      jk[i] = RST ? (RST_VAL[i] ? JK_SET : JK_RESET) :
              Load ? (D[i] ? JK_SET : JK_RESET) :
              (En & tog[i] & ~sat) ? JK_TOGGLE : JK_HOLD;
  end
  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    assign J_mon[g] = jk[g][1];
    assign K_mon[g] = jk[g][0];
    jk_ff_cell u_cell (
      .Clk  (Clk),
      .J    (jk[g][1]),
      .K    (jk[g][0]),
      .Q    (q[g]),
      .Q_not(q_n[g])
    );
  end
endmodule

// File: tb/tb_jk_sync_counter.sv
// tb_jk_sync_counter: directed scoreboard bench for jk_sync_counter (WIDTH=4)
module tb_jk_sync_counter;
`ifdef JK_CNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef struct {
    string name;
    bit cq;
    logic [3:0] q;
    logic tc;
    bit cjk;
    logic [3:0] j;
    logic [3:0] k;
  } exp_t;
  logic Clk, RST, En, Up, Load, TC;
  logic [3:0] D, Q, J_mon, K_mon;
  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  jk_sync_counter #(.WIDTH(4), .RST_VAL(4'h0)) dut (
    .Clk(Clk), .RST(RST), .En(En), .Up(Up), .Load(Load), .D(D),
    .Q(Q), .TC(TC), .J_mon(J_mon), .K_mon(K_mon)
  );
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end
  task automatic chk(input string name, input string field, input logic [3:0] got, input logic [3:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s.%s got=%h want=%h", name, field, got, want);
    end
  endtask
  always @(negedge Clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.cq) chk(e.name, "Q", Q, e.q);
      chk(e.name, "TC", {3'b0, TC}, {3'b0, e.tc});
      if (e.cjk) begin
        chk(e.name, "J", J_mon, e.j);
        chk(e.name, "K", K_mon, e.k);
      end
    end
  end
  task automatic row(input string name, input bit rst, load, en, up, input logic [3:0] d,
                     input bit cq, input logic [3:0] q, input bit tc,
                     input logic [3:0] j, k, input bit cjk);
    exp_t e;
    @(posedge Clk);
    #1;
    RST = rst; Load = load; En = en; Up = up; D = d;
    e.name = name; e.cq = cq; e.q = q; e.tc = tc; e.cjk = cjk; e.j = j; e.k = k;
    sb.push_back(e);
  endtask
  initial begin
    int budget;
    RST = 0; Load = 0; En = 0; Up = 0; D = 0;
    row("rst", 1, 1, 1, 1, 4'hA, 0, 4'h0, 0, 4'h0, 4'hF, 1);
    row("up0", 0, 0, 1, 1, 4'h0, 1, 4'h0, 0, 4'h1, 4'h1, 1);
    for (int i = 1; i < 16; i++)
      row("up", 0, 0, 1, 1, 4'h0, 1, 4'(i), i == 15,
          (i == 3) ? 4'h7 : (i == 15 && SAT) ? 4'h0 : 4'hF,
          (i == 3) ? 4'h7 : (i == 15 && SAT) ? 4'h0 : 4'hF,
          i == 3 || i == 7 || i == 15);
    row("ld2", 0, 1, 1, 0, 4'h2, !SAT, 4'h0, 0, 4'h2, 4'hD, 1);
    row("dn2", 0, 0, 1, 0, 4'h0, 1, 4'h2, 0, 4'h3, 4'h3, 1);
    row("dn1", 0, 0, 1, 0, 4'h0, 1, 4'h1, 0, 4'h1, 4'h1, 1);
    row("dn0", 0, 0, 1, 0, 4'h0, 1, 4'h0, 1, SAT ? 4'h0 : 4'hF, SAT ? 4'h0 : 4'hF, 1);
    row("dnw", 0, 0, 1, 0, 4'h0, !SAT, 4'hF, SAT, SAT ? 4'h0 : 4'h1, SAT ? 4'h0 : 4'h1, 1);
    row("ld3", 0, 1, 0, 0, 4'h3, !SAT, 4'hE, 0, 4'h3, 4'hC, 1);
    row("ldpri", 0, 1, 1, 1, 4'hA, 1, 4'h3, 0, 4'hA, 4'h5, 1);
    row("ld6", 0, 1, 0, 0, 4'h6, 1, 4'hA, 0, 4'h6, 4'h9, 1);
    for (int i = 0; i < 3; i++)
      row("hold", 0, 0, 0, 1, 4'h0, 1, 4'h6, 0, 4'h0, 4'h0, 1);
    row("flip_up", 0, 0, 1, 1, 4'h0, 1, 4'h6, 0, 4'h1, 4'h1, 1);
    row("flip_dn", 0, 0, 1, 0, 4'h0, 1, 4'h7, 0, 4'h1, 4'h1, 1);
    row("flip_up2", 0, 0, 1, 1, 4'h0, 1, 4'h6, 0, 4'h1, 4'h1, 1);
    row("flip_dn2", 0, 0, 1, 0, 4'h0, 1, 4'h7, 0, 4'h1, 4'h1, 1);
    row("rst_mid", 1, 1, 1, 1, 4'hF, 1, 4'h6, 0, 4'h0, 4'hF, 1);
    row("idle0", 0, 0, 0, 0, 4'h0, 1, 4'h0, 0, 4'h0, 4'h0, 1);
`ifdef JK_CNT_SATURATE_EN
    row("ldE", 0, 1, 0, 0, 4'hE, 1, 4'h0, 0, 4'hE, 4'h1, 1);
    row("s14", 0, 0, 1, 1, 4'h0, 1, 4'hE, 0, 4'h1, 4'h1, 1);
    for (int i = 0; i < 3; i++)
      row("sat15", 0, 0, 1, 1, 4'h0, 1, 4'hF, 1, 4'h0, 4'h0, 1);
    row("sat_dn", 0, 0, 1, 0, 4'h0, 1, 4'hF, 0, 4'h1, 4'h1, 1);
    row("sat_end", 0, 0, 0, 0, 4'h0, 1, 4'hE, 0, 4'h0, 4'h0, 1);
`else
    row("wrap0", 0, 0, 1, 0, 4'h0, 1, 4'h0, 1, 4'hF, 4'hF, 1);
    row("wrap15", 0, 0, 0, 0, 4'h0, 1, 4'hF, 0, 4'h0, 4'h0, 1);
`endif
    budget = 10;
    while (sb.size() != 0 && budget > 0) begin
      @(posedge Clk);
      budget--;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
